// File: rtl/cache_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : cache_exerciser
// Purpose  : Writes a linear data pattern over an address window on the cache
//            front-end port, then reads it back and reports errors/timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module cache_exerciser #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           WORD_COUNT     = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           STRIDE         = 4,
    parameter logic [31:0]           SEED           = 32'h1234_5678,
    parameter int unsigned           PAT_STEP       = 1,
    parameter int unsigned           TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  data_out_valid
);

    localparam int c_idx_w  = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int c_wait_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_idx_w-1:0]    c_last_idx  = c_idx_w'(WORD_COUNT - 1);
    localparam logic [c_wait_w-1:0]   c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_stride    = ADDR_WIDTH'(STRIDE);
    localparam logic [DATA_WIDTH-1:0] c_pat_step  = DATA_WIDTH'(PAT_STEP);
    localparam logic [DATA_WIDTH-1:0] c_seed      = DATA_WIDTH'(SEED);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_GAP   = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [c_idx_w-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic [c_wait_w-1:0]   wait_q, wait_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  to_q, to_d;
    logic                  w_step;
    logic                  w_err_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            pat_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            first_q <= first_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        wait_d    = wait_q;
        err_d     = err_q;
        first_d   = first_q;
        to_d      = to_q;
        w_step    = 1'b0;
        w_err_hit = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    pat_d   = c_seed;
                    err_d   = '0;
                    first_d = '0;
                    to_d    = 1'b0;
                    state_d = (mode == 2'd1) ? ST_RD_ISSUE : ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: state_d = ST_WR_GAP;
            ST_WR_GAP: begin
                if (idx_q == c_last_idx) begin
                    if (mode_q == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = '0;
                        addr_d  = BASE_ADDR;
                        pat_d   = c_seed;
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = addr_q + c_stride;
                    pat_d   = pat_q + c_pat_step;
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                wait_d  = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Valid data wins over a timeout landing on the same cycle.
                if (data_out_valid) begin
                    w_step    = 1'b1;
                    w_err_hit = (data_out != pat_q);
                end else if (wait_q == c_wait_last) begin
                    w_step    = 1'b1;
                    w_err_hit = 1'b1;
                    to_d      = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (w_step) begin
                    if (idx_q == c_last_idx) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = addr_q + c_stride;
                        pat_d   = pat_q + c_pat_step;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_err_hit) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                first_d = addr_q;
            end
        end
    end

    assign busy           = (state_q inside {ST_WR_ISSUE, ST_WR_GAP, ST_RD_ISSUE, ST_RD_WAIT});
    assign done           = (state_q == ST_DONE);
    assign pass           = done && ((mode_q == 2'd0) || ((err_q == 16'd0) && !to_q));
    assign write_enable   = (state_q == ST_WR_ISSUE);
    assign data_in        = write_enable ? pat_q : '0;
    assign address        = addr_q;
    assign error_count    = err_q;
    assign first_err_addr = first_q;
    assign timeout        = to_q;

endmodule
`default_nettype wire
